// File: rtl/id_ex_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_pkg
//   Shared definitions for the ID/EX pipeline register and its ALU-control
//   decoder: ALU control codes, aluOp encodings, R-type funct values and the
//   bit positions inside the ID and EX control bundles.
// ---------------------------------------------------------------------------
package id_ex_stage_pkg;

    // 4-bit ALU control codes driven to the ALU
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // aluOp field produced by the main decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_SLT   = 2'b11
    } alu_op_e;

    // R-type funct values understood by the ALU
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ID control bundle {regDst,aluSrc,regWrite,memRead,memWrite,memToReg,branch}
    localparam int ID_CTRL_W    = 7;
    localparam int CTRL_REG_DST = 6;
    localparam int CTRL_ALU_SRC = 5;
    localparam int CTRL_MEM_WR  = 2;
    localparam int CTRL_BRANCH  = 0;

    // EX control bundle {regWrite,memRead,memWrite,memToReg,branch}
    localparam int EX_CTRL_W    = 5;
    localparam int EX_REG_WRITE = 4;
    localparam int EX_MEM_READ  = 3;

endpackage

// File: rtl/id_ex_stage_alu_ctrl_dec.sv
// ---------------------------------------------------------------------------
// id_ex_stage_alu_ctrl_dec
//   Combinational ALU-control decoder.
//   Ports:
//     alu_op   in  2  aluOp from the main decoder
//     funct    in  6  instruction funct field (used only for R-type)
//     alu_ctr  out 4  ALU control code
//   Unknown R-type funct values fall back to ADD.
// ---------------------------------------------------------------------------
module id_ex_stage_alu_ctrl_dec
    import id_ex_stage_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [3:0] alu_ctr
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first;
        // a path that leaves it unassigned would infer a latch.
        alu_ctr = ALU_ADD;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: alu_ctr = ALU_ADD;
            ALUOP_SUB: alu_ctr = ALU_SUB;
            ALUOP_SLT: alu_ctr = ALU_SLT;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: alu_ctr = ALU_ADD;
                    FUNCT_SUB: alu_ctr = ALU_SUB;
                    FUNCT_AND: alu_ctr = ALU_AND;
                    FUNCT_OR:  alu_ctr = ALU_OR;
                    FUNCT_SLT: alu_ctr = ALU_SLT;
                    default:   alu_ctr = ALU_ADD;
                endcase
            end
            default: alu_ctr = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register of a 5-stage MIPS datapath. Decodes the ALU
//   control, selects forwarded operands (EX > MEM > WB > regfile), detects
//   load-use hazards and inserts bubbles, and honours hold/flush.
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     hold                          freeze the whole pipeline
//     flush                         squash the ID instruction (bubble into EX)
//     id_valid, id_ctrl, id_aluOp,
//     id_funct, id_rs/rt/rd,
//     id_rsData, id_rtData, id_imm  decoded instruction in ID
//     alu_res                       ALU result of the instruction now in EX
//     mem_regWrite/WriteReg/fwdData MEM-stage forwarding source
//     wb_regWrite/writeReg/data     WB-stage forwarding source
//     stall_id                      freeze PC and IF/ID (combinational)
//     ex_*                          registered EX-stage outputs
// ---------------------------------------------------------------------------
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 id_valid,
    input  logic [6:0]           id_ctrl,
    input  logic [1:0]           id_aluOp,
    input  logic [5:0]           id_funct,
    input  logic [REG_W-1:0]     id_rs,
    input  logic [REG_W-1:0]     id_rt,
    input  logic [REG_W-1:0]     id_rd,
    input  logic [DATA_W-1:0]    id_rsData,
    input  logic [DATA_W-1:0]    id_rtData,
    input  logic [DATA_W-1:0]    id_imm,
    input  logic [DATA_W-1:0]    alu_res,
    input  logic                 mem_regWrite,
    input  logic [REG_W-1:0]     mem_writeReg,
    input  logic [DATA_W-1:0]    mem_fwdData,
    input  logic                 wb_regWrite,
    input  logic [REG_W-1:0]     wb_writeReg,
    input  logic [DATA_W-1:0]    wb_data,
    output logic                 stall_id,
    output logic                 ex_valid,
    output logic [DATA_W-1:0]    ex_input1,
    output logic [DATA_W-1:0]    ex_input2,
    output logic [3:0]           ex_aluCtr,
    output logic [DATA_W-1:0]    ex_storeData,
    output logic [REG_W-1:0]     ex_writeReg,
    output logic [4:0]           ex_ctrl
);

    // EX-stage state
    logic                 valid_q,      valid_d;
    logic [EX_CTRL_W-1:0] ctrl_q,       ctrl_d;
    logic [DATA_W-1:0]    input1_q,     input1_d;
    logic [DATA_W-1:0]    input2_q,     input2_d;
    logic [3:0]           alu_ctr_q,    alu_ctr_d;
    logic [DATA_W-1:0]    store_data_q, store_data_d;
    logic [REG_W-1:0]     write_reg_q,  write_reg_d;

    logic [3:0]        id_alu_ctr;
    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;
    logic              reads_rt;
    logic              load_use;

    id_ex_stage_alu_ctrl_dec u_alu_ctrl_dec (
        .alu_op  (id_aluOp),
        .funct   (id_funct),
        .alu_ctr (id_alu_ctr)
    );

    // Operand source priority: EX > MEM > WB > regfile. $0 always reads 0.
    // A load in EX has no data yet, so it is never a forwarding source.
    function automatic logic [DATA_W-1:0] fwd(input logic [REG_W-1:0] r,
                                              input logic [DATA_W-1:0] rf_data);
        if (r == '0)
            return '0;
        if (valid_q && ctrl_q[EX_REG_WRITE] && !ctrl_q[EX_MEM_READ] && write_reg_q == r)
            return alu_res;
        if (mem_regWrite && mem_writeReg == r)
            return mem_fwdData;
        if (wb_regWrite && wb_writeReg == r)
            return wb_data;
        return rf_data;
    endfunction

    always_comb begin
        fwd_rs   = fwd(id_rs, id_rsData);
        fwd_rt   = fwd(id_rt, id_rtData);

        // rt is a source for R-type, stores and branches; for loads/immediates
        // it is only the destination.
        reads_rt = id_ctrl[CTRL_REG_DST] | id_ctrl[CTRL_MEM_WR] | id_ctrl[CTRL_BRANCH];
        load_use = id_valid & valid_q & ctrl_q[EX_MEM_READ] & (write_reg_q != '0) &
                   ((write_reg_q == id_rs) | (reads_rt & (write_reg_q == id_rt)));

        // A taken branch squashes the dependent instruction, so no stall.
        stall_id = hold | (load_use & ~flush);
    end

    always_comb begin
        valid_d      = valid_q;
        ctrl_d       = ctrl_q;
        input1_d     = input1_q;
        input2_d     = input2_q;
        alu_ctr_d    = alu_ctr_q;
        store_data_d = store_data_q;
        write_reg_d  = write_reg_q;

        if (!hold) begin
            if (flush || load_use || !id_valid) begin
                valid_d      = 1'b0;
                ctrl_d       = '0;
                input1_d     = '0;
                input2_d     = '0;
                alu_ctr_d    = '0;
                store_data_d = '0;
                write_reg_d  = '0;
            end else begin
                valid_d      = 1'b1;
                ctrl_d       = id_ctrl[EX_CTRL_W-1:0];
                input1_d     = fwd_rs;
                input2_d     = id_ctrl[CTRL_ALU_SRC] ? id_imm : fwd_rt;
                alu_ctr_d    = id_alu_ctr;
                store_data_d = fwd_rt;
                write_reg_d  = id_ctrl[CTRL_REG_DST] ? id_rd : id_rt;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            valid_q      <= 1'b0;
            ctrl_q       <= '0;
            input1_q     <= '0;
            input2_q     <= '0;
            alu_ctr_q    <= '0;
            store_data_q <= '0;
            write_reg_q  <= '0;
        end else begin
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            input1_q     <= input1_d;
            input2_q     <= input2_d;
            alu_ctr_q    <= alu_ctr_d;
            store_data_q <= store_data_d;
            write_reg_q  <= write_reg_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_input1    = input1_q;
    assign ex_input2    = input2_q;
    assign ex_aluCtr    = alu_ctr_q;
    assign ex_storeData = store_data_q;
    assign ex_writeReg  = write_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed bench for id_ex_stage. Each step drives an ID instruction plus
//   the forwarding sources, pushes the hand-derived EX contents onto a
//   scoreboard queue, and pops/compares one cycle later.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DW = 32;
    localparam int RW = 5;

    // ID control encodings {regDst,aluSrc,regWrite,memRead,memWrite,memToReg,branch}
    localparam logic [6:0] C_R   = 7'b1010000;
    localparam logic [6:0] C_LW  = 7'b0111010;
    localparam logic [6:0] C_IMM = 7'b0110000;
    localparam logic [6:0] C_BR  = 7'b0000001;
    // Resulting EX control {regWrite,memRead,memWrite,memToReg,branch}
    localparam logic [4:0] X_R   = 5'b10000;
    localparam logic [4:0] X_LW  = 5'b11010;
    localparam logic [4:0] X_BR  = 5'b00001;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hold, flush;
    logic          id_valid;
    logic [6:0]    id_ctrl;
    logic [1:0]    id_aluOp;
    logic [5:0]    id_funct;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rsData, id_rtData, id_imm;
    logic [DW-1:0] alu_res;
    logic          mem_regWrite;
    logic [RW-1:0] mem_writeReg;
    logic [DW-1:0] mem_fwdData;
    logic          wb_regWrite;
    logic [RW-1:0] wb_writeReg;
    logic [DW-1:0] wb_data;
    logic          stall_id;
    logic          ex_valid;
    logic [DW-1:0] ex_input1, ex_input2, ex_storeData;
    logic [3:0]    ex_aluCtr;
    logic [RW-1:0] ex_writeReg;
    logic [4:0]    ex_ctrl;

    id_ex_stage #(.DATA_W(DW), .REG_W(RW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ctrl      (id_ctrl),
        .id_aluOp     (id_aluOp),
        .id_funct     (id_funct),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .id_rsData    (id_rsData),
        .id_rtData    (id_rtData),
        .id_imm       (id_imm),
        .alu_res      (alu_res),
        .mem_regWrite (mem_regWrite),
        .mem_writeReg (mem_writeReg),
        .mem_fwdData  (mem_fwdData),
        .wb_regWrite  (wb_regWrite),
        .wb_writeReg  (wb_writeReg),
        .wb_data      (wb_data),
        .stall_id     (stall_id),
        .ex_valid     (ex_valid),
        .ex_input1    (ex_input1),
        .ex_input2    (ex_input2),
        .ex_aluCtr    (ex_aluCtr),
        .ex_storeData (ex_storeData),
        .ex_writeReg  (ex_writeReg),
        .ex_ctrl      (ex_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [4:0]    ctrl;
        logic [DW-1:0] in1;
        logic [DW-1:0] in2;
        logic [3:0]    ac;
        logic [DW-1:0] st;
        logic [RW-1:0] wr;
    } exp_t;

    localparam exp_t BUBBLE = '0;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [4:0] ctrl, input logic [DW-1:0] in1,
                                input logic [DW-1:0] in2, input logic [3:0] ac,
                                input logic [DW-1:0] st, input logic [RW-1:0] wr);
        exp_t e;
        e.v    = 1'b1;
        e.ctrl = ctrl;
        e.in1  = in1;
        e.in2  = in2;
        e.ac   = ac;
        e.st   = st;
        e.wr   = wr;
        return e;
    endfunction

    task automatic drive_id(input logic v, input logic [6:0] c, input logic [1:0] op,
                            input logic [5:0] f, input logic [RW-1:0] rs,
                            input logic [RW-1:0] rt, input logic [RW-1:0] rd,
                            input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                            input logic [DW-1:0] imm);
        id_valid  = v;
        id_ctrl   = c;
        id_aluOp  = op;
        id_funct  = f;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        id_rsData = rsd;
        id_rtData = rtd;
        id_imm    = imm;
    endtask

    task automatic set_mem(input logic we, input logic [RW-1:0] r, input logic [DW-1:0] d);
        mem_regWrite = we;
        mem_writeReg = r;
        mem_fwdData  = d;
    endtask

    task automatic set_wb(input logic we, input logic [RW-1:0] r, input logic [DW-1:0] d);
        wb_regWrite = we;
        wb_writeReg = r;
        wb_data     = d;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        #1;
        check({tag, ".stall_id"}, 32'(stall_id), 32'(exp));
    endtask

    // Push the expectation, clock once, then pop and compare all EX outputs.
    task automatic step(input string tag, input exp_t e);
        exp_t got;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, ".ex_valid"},     32'(ex_valid),     32'(got.v));
        check({tag, ".ex_ctrl"},      32'(ex_ctrl),      32'(got.ctrl));
        check({tag, ".ex_input1"},    ex_input1,         got.in1);
        check({tag, ".ex_input2"},    ex_input2,         got.in2);
        check({tag, ".ex_aluCtr"},    32'(ex_aluCtr),    32'(got.ac));
        check({tag, ".ex_storeData"}, ex_storeData,      got.st);
        check({tag, ".ex_writeReg"},  32'(ex_writeReg),  32'(got.wr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges while ID presents a real instruction.
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        alu_res = '0;
        set_mem(1'b0, '0, '0);
        set_wb(1'b0, '0, '0);
        drive_id(1'b1, C_R, 2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, '0);
        step("rst0", BUBBLE);
        step("rst1", BUBBLE);
        check_stall("rst", 1'b0);
        rst_n = 1'b1;

        // add $3,$1,$2 -- nothing to forward from an empty EX
        drive_id(1'b1, C_R, 2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'h10, 32'h5, '0);
        check_stall("add3", 1'b0);
        step("add3", mk(X_R, 32'h10, 32'h5, 4'b0010, 32'h5, 5'd3));

        // sub $4,$3,$1 with stale rs data; $3 comes from EX
        alu_res = 32'h15;
        drive_id(1'b1, C_R, 2'b10, 6'b100010, 5'd3, 5'd1, 5'd4, 32'h0, 32'h10, '0);
        check_stall("sub4", 1'b0);
        step("sub4", mk(X_R, 32'h15, 32'h10, 4'b0110, 32'h10, 5'd4));

        // or $5,$1,$2 -- no register match with EX ($4)
        alu_res = 32'h44;
        drive_id(1'b1, C_R, 2'b10, 6'b100101, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, '0);
        step("or5", mk(X_R, 32'h1, 32'h2, 4'b0001, 32'h2, 5'd5));

        // and $6,$5,$0: EX beats MEM for $5; $0 stays 0 despite WB writing it
        alu_res = 32'h7;
        set_mem(1'b1, 5'd5, 32'h9);
        set_wb(1'b1, 5'd0, 32'hFFFF);
        drive_id(1'b1, C_R, 2'b10, 6'b100100, 5'd5, 5'd0, 5'd6, 32'h55, 32'h1234, '0);
        step("and6", mk(X_R, 32'h7, 32'h0, 4'b0000, 32'h0, 5'd6));

        // slt $9,$7,$8: rs from MEM, rt from WB
        alu_res = 32'hAA;
        set_mem(1'b1, 5'd7, 32'h77);
        set_wb(1'b1, 5'd8, 32'h88);
        drive_id(1'b1, C_R, 2'b10, 6'b101010, 5'd7, 5'd8, 5'd9, 32'h0, 32'h0, '0);
        step("slt9", mk(X_R, 32'h77, 32'h88, 4'b0111, 32'h88, 5'd9));

        // lw $2,4($1)
        set_mem(1'b0, '0, '0);
        set_wb(1'b0, '0, '0);
        drive_id(1'b1, C_LW, 2'b00, 6'b000000, 5'd1, 5'd2, 5'd0, 32'h100, 32'h3, 32'h4);
        check_stall("lw2", 1'b0);
        step("lw2", mk(X_LW, 32'h100, 32'h4, 4'b0010, 32'h3, 5'd2));

        // add $4,$2,$2 right behind the load: stall one cycle, bubble
        drive_id(1'b1, C_R, 2'b10, 6'b100000, 5'd2, 5'd2, 5'd4, 32'h0, 32'h0, '0);
        check_stall("luse", 1'b1);
        step("luse", BUBBLE);

        // load now in MEM: stall released, both operands from mem_fwdData
        set_mem(1'b1, 5'd2, 32'hBEEF);
        check_stall("luse_go", 1'b0);
        step("luse_go", mk(X_R, 32'hBEEF, 32'hBEEF, 4'b0010, 32'hBEEF, 5'd4));

        // lw $2,8($1) again, then the dependent add under flush
        set_mem(1'b0, '0, '0);
        alu_res = '0;
        drive_id(1'b1, C_LW, 2'b00, 6'b000000, 5'd1, 5'd2, 5'd0, 32'h200, 32'h3, 32'h8);
        step("lw2b", mk(X_LW, 32'h200, 32'h8, 4'b0010, 32'h3, 5'd2));

        drive_id(1'b1, C_R, 2'b10, 6'b100000, 5'd2, 5'd2, 5'd4, 32'h0, 32'h0, '0);
        flush = 1'b1;
        check_stall("flush", 1'b0);
        step("flush", BUBBLE);
        flush = 1'b0;

        // addi $10,$1,-4
        drive_id(1'b1, C_IMM, 2'b00, 6'b000000, 5'd1, 5'd10, 5'd0, 32'h20, 32'h0, 32'hFFFF_FFFC);
        step("addi", mk(X_R, 32'h20, 32'hFFFF_FFFC, 4'b0010, 32'h0, 5'd10));

        // hold for three cycles while ID changes underneath
        hold = 1'b1;
        drive_id(1'b1, C_R, 2'b10, 6'b100010, 5'd10, 5'd3, 5'd7, 32'h99, 32'h98, '0);
        for (int i = 0; i < 3; i++) begin
            check_stall("hold", 1'b1);
            step("hold", mk(X_R, 32'h20, 32'hFFFF_FFFC, 4'b0010, 32'h0, 5'd10));
        end
        hold = 1'b0;

        // R-type with unknown funct 000000 falls back to add
        drive_id(1'b1, C_R, 2'b10, 6'b000000, 5'd3, 5'd4, 5'd11, 32'h3, 32'h4, '0);
        step("f000", mk(X_R, 32'h3, 32'h4, 4'b0010, 32'h4, 5'd11));

        // beq-style: aluOp 01, rs from EX, rt=$0
        alu_res = 32'h1B;
        drive_id(1'b1, C_BR, 2'b01, 6'b000000, 5'd11, 5'd0, 5'd0, 32'h0, 32'h5, '0);
        step("beq", mk(X_BR, 32'h1B, 32'h0, 4'b0110, 32'h0, 5'd0));

        // slti $12,$0,5: aluOp 11
        drive_id(1'b1, C_IMM, 2'b11, 6'b000000, 5'd0, 5'd12, 5'd0, 32'h77, 32'h9, 32'h5);
        step("slti", mk(X_R, 32'h0, 32'h5, 4'b0111, 32'h9, 5'd12));

        // invalid ID slot loads a bubble
        drive_id(1'b0, C_R, 2'b10, 6'b100000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, '0);
        step("inval", BUBBLE);

        // reset in the middle of a load-use stall
        drive_id(1'b1, C_LW, 2'b00, 6'b000000, 5'd1, 5'd2, 5'd0, 32'h300, 32'h0, 32'h0);
        step("lw2c", mk(X_LW, 32'h300, 32'h0, 4'b0010, 32'h0, 5'd2));
        drive_id(1'b1, C_R, 2'b10, 6'b100000, 5'd2, 5'd2, 5'd4, 32'h0, 32'h0, '0);
        check_stall("rst_stall", 1'b1);
        rst_n = 1'b0;
        step("rst_stall", BUBBLE);
        check_stall("rst_after", 1'b0);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
